fetch_ctrl: RTL and testbench

//  Sequences the instruction-fetch stage: drives its freeze, branch_taken and branch_addr inputs,
//  and the IF/ID register's freeze and flush. Merges the hazard stall, EX-stage branch redirects
//  and an instruction-memory ready signal. A redirect that arrives while memory is not ready is

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_ctrl_sat_counter.sv | 40 ++++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared widths and state encoding for the instruction-fetch controller.
//   WORD_WIDTH      : PC / branch-target width
//   PERF_CNT_WIDTH  : width of the saturating performance counters
//   fctrl_state_e   : RUN (normal fetch) / PEND (redirect held until imem ready)
package fetch_ctrl_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int PERF_CNT_WIDTH = 16;

    typedef enum logic {
        FCTRL_RUN  = 1'b0,
        FCTRL_PEND = 1'b1
    } fctrl_state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear that beats increment.
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (count -> 0)
//   clr_i    in   synchronous clear
//   inc_i    in   count this cycle
//   count_o  out  current count, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Sequences the instruction-fetch stage. Merges the hazard stall, EX-stage
//   branch redirects and instruction-memory ready into PC freeze / redirect
//   controls and IF/ID freeze / flush. A redirect arriving while memory is
//   not ready is held (PEND) and applied on the first ready cycle.
//   Outputs are combinational from state, held target and inputs.
//   clk_i, rst_ni         clock / asynchronous active-low reset
//   hazard_stall_i        hold PC and IF/ID
//   ex_branch_taken_i     EX resolves a taken branch
//   ex_branch_addr_i      branch target from EX
//   imem_ready_i          instruction word valid this cycle
//   perf_clr_i            synchronous clear of both counters
//   if_freeze_o           PC hold
//   if_branch_taken_o     PC loads if_branch_addr_o
//   if_branch_addr_o      redirect target (0 when not redirecting)
//   ifid_freeze_o         hold IF/ID
//   ifid_flush_o          load a bubble into IF/ID
//   stall_cnt_o           saturating count of if_freeze_o cycles
//   redirect_cnt_o        saturating count of if_branch_taken_o cycles
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = fetch_ctrl_pkg::WORD_WIDTH,
    parameter int CNT_WIDTH  = PERF_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hazard_stall_i,
    input  logic                  ex_branch_taken_i,
    input  logic [WORD_WIDTH-1:0] ex_branch_addr_i,
    input  logic                  imem_ready_i,
    input  logic                  perf_clr_i,
    output logic                  if_freeze_o,
    output logic                  if_branch_taken_o,
    output logic [WORD_WIDTH-1:0] if_branch_addr_o,
    output logic                  ifid_freeze_o,
    output logic                  ifid_flush_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

    fctrl_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [WORD_WIDTH-1:0] tgt;

    always_comb begin
        state_d           = state_q;
        pend_addr_d       = pend_addr_q;
        if_freeze_o       = 1'b0;
        if_branch_taken_o = 1'b0;
        if_branch_addr_o  = '0;
        ifid_freeze_o     = 1'b0;
        ifid_flush_o      = 1'b0;
        // In PEND a newer EX redirect supersedes the held target.
        tgt = ex_branch_taken_i ? ex_branch_addr_i : pend_addr_q;

        if (!rst_ni) begin
            // Keep a bubble in IF/ID while the pipeline is in reset.
            ifid_flush_o = 1'b1;
        end else begin
            case (state_q)
                FCTRL_RUN: begin
                    if (ex_branch_taken_i && imem_ready_i) begin
                        // Redirect wins over a hazard stall: the stalled
                        // instruction is on the wrong path anyway.
                        if_branch_taken_o = 1'b1;
                        if_branch_addr_o  = ex_branch_addr_i;
                        ifid_flush_o      = 1'b1;
                    end else if (ex_branch_taken_i) begin
                        pend_addr_d  = ex_branch_addr_i;
                        state_d      = FCTRL_PEND;
                        if_freeze_o  = 1'b1;
                        ifid_flush_o = 1'b1;
                    end else if (hazard_stall_i) begin
                        if_freeze_o   = 1'b1;
                        ifid_freeze_o = 1'b1;
                    end else if (!imem_ready_i) begin
                        if_freeze_o  = 1'b1;
                        ifid_flush_o = 1'b1;
                    end
                end
                FCTRL_PEND: begin
                    pend_addr_d  = tgt;
                    ifid_flush_o = 1'b1;
                    if (imem_ready_i) begin
                        if_branch_taken_o = 1'b1;
                        if_branch_addr_o  = tgt;
                        state_d           = FCTRL_RUN;
                    end else begin
                        if_freeze_o = 1'b1;
                    end
                end
                default: begin
                    state_d = FCTRL_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FCTRL_RUN;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (perf_clr_i),
        .inc_i   (if_freeze_o),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (perf_clr_i),
        .inc_i   (if_branch_taken_o),
        .count_o (redirect_cnt_o)
    );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Directed, table-driven bench for fetch_ctrl. Inputs change on the falling
//   edge; combinational outputs and counters are compared 1 time unit later.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_addr = '0;
    logic        imem_ready = 1'b1;
    logic        perf_clr = 1'b0;
    logic        if_freeze;
    logic        if_branch_taken;
    logic [31:0] if_branch_addr;
    logic        ifid_freeze;
    logic        ifid_flush;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_ctrl dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .hazard_stall_i    (hazard_stall),
        .ex_branch_taken_i (ex_branch_taken),
        .ex_branch_addr_i  (ex_branch_addr),
        .imem_ready_i      (imem_ready),
        .perf_clr_i        (perf_clr),
        .if_freeze_o       (if_freeze),
        .if_branch_taken_o (if_branch_taken),
        .if_branch_addr_o  (if_branch_addr),
        .ifid_freeze_o     (ifid_freeze),
        .ifid_flush_o      (ifid_flush),
        .stall_cnt_o       (stall_cnt),
        .redirect_cnt_o    (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        hz;
        logic        bt;
        logic [31:0] addr;
        logic        rdy;
        logic        clr;
        logic        f;
        logic        b;
        logic [31:0] a;
        logic        z;
        logic        l;
        logic [15:0] sc;
        logic [15:0] rc;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic hz, logic bt, logic [31:0] addr, logic rdy,
                                logic clr, logic f, logic b, logic [31:0] a, logic z, logic l,
                                logic [15:0] sc, logic [15:0] rc);
        vec_t v;
        v.rst_n = r;  v.hz = hz; v.bt = bt; v.addr = addr; v.rdy = rdy; v.clr = clr;
        v.f = f; v.b = b; v.a = a; v.z = z; v.l = l; v.sc = sc; v.rc = rc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int i);
        string p;
        p = $sformatf("v%0d", i);
        check({p, ".if_freeze"},       {31'd0, if_freeze},       {31'd0, vecs[i].f});
        check({p, ".if_branch_taken"}, {31'd0, if_branch_taken}, {31'd0, vecs[i].b});
        check({p, ".if_branch_addr"},  if_branch_addr,           vecs[i].a);
        check({p, ".ifid_freeze"},     {31'd0, ifid_freeze},     {31'd0, vecs[i].z});
        check({p, ".ifid_flush"},      {31'd0, ifid_flush},      {31'd0, vecs[i].l});
        check({p, ".stall_cnt"},       {16'd0, stall_cnt},       {16'd0, vecs[i].sc});
        check({p, ".redirect_cnt"},    {16'd0, redirect_cnt},    {16'd0, vecs[i].rc});
        $display("vec %0d: rst_n=%0b hz=%0b bt=%0b addr=0x%0h rdy=%0b clr=%0b -> f=%0b b=%0b a=0x%0h z=%0b l=%0b sc=%0d rc=%0d",
                 i, vecs[i].rst_n, vecs[i].hz, vecs[i].bt, vecs[i].addr, vecs[i].rdy, vecs[i].clr,
                 if_freeze, if_branch_taken, if_branch_addr, ifid_freeze, ifid_flush,
                 stall_cnt, redirect_cnt);
    endtask

    initial begin
        //             rst hz bt addr   rdy clr | f  b  a      z  l  sc rc
        // reset forces outputs even with a branch present
        vecs[0]  = mk(0, 0, 1, 32'h40, 1, 0,   0, 0, 32'h0,  0, 1, 0, 0);
        vecs[1]  = mk(1, 0, 0, 32'h0,  1, 0,   0, 0, 32'h0,  0, 0, 0, 0);
        // immediate redirect
        vecs[2]  = mk(1, 0, 1, 32'h40, 1, 0,   0, 1, 32'h40, 0, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 32'h0,  1, 0,   0, 0, 32'h0,  0, 0, 0, 1);
        // held redirect over 3 not-ready cycles (hazard ignored in PEND)
        vecs[4]  = mk(1, 0, 1, 32'h80, 0, 0,   1, 0, 32'h0,  0, 1, 0, 1);
        vecs[5]  = mk(1, 1, 0, 32'h0,  0, 0,   1, 0, 32'h0,  0, 1, 1, 1);
        vecs[6]  = mk(1, 0, 0, 32'h0,  0, 0,   1, 0, 32'h0,  0, 1, 2, 1);
        vecs[7]  = mk(1, 0, 0, 32'h0,  1, 0,   0, 1, 32'h80, 0, 1, 3, 1);
        vecs[8]  = mk(1, 0, 0, 32'h0,  1, 0,   0, 0, 32'h0,  0, 0, 3, 2);
        // newer redirect replaces the held one
        vecs[9]  = mk(1, 0, 1, 32'h80, 0, 0,   1, 0, 32'h0,  0, 1, 3, 2);
        vecs[10] = mk(1, 0, 1, 32'hC0, 1, 0,   0, 1, 32'hC0, 0, 1, 4, 2);
        vecs[11] = mk(1, 0, 0, 32'h0,  1, 0,   0, 0, 32'h0,  0, 0, 4, 3);
        // branch beats hazard; hazard beats not-ready
        vecs[12] = mk(1, 1, 1, 32'h10, 1, 0,   0, 1, 32'h10, 0, 1, 4, 3);
        vecs[13] = mk(1, 1, 0, 32'h0,  1, 0,   1, 0, 32'h0,  1, 0, 4, 4);
        vecs[14] = mk(1, 0, 0, 32'h0,  0, 0,   1, 0, 32'h0,  0, 1, 5, 4);
        vecs[15] = mk(1, 1, 0, 32'h0,  0, 0,   1, 0, 32'h0,  1, 0, 6, 4);
        // perf_clr
        vecs[16] = mk(1, 0, 0, 32'h0,  1, 1,   0, 0, 32'h0,  0, 0, 7, 4);
        vecs[17] = mk(1, 0, 0, 32'h0,  1, 0,   0, 0, 32'h0,  0, 0, 0, 0);
        // reset mid-PEND drops the held redirect
        vecs[18] = mk(1, 0, 1, 32'h44, 0, 0,   1, 0, 32'h0,  0, 1, 0, 0);
        vecs[19] = mk(0, 0, 0, 32'h0,  0, 0,   0, 0, 32'h0,  0, 1, 0, 0);
        vecs[20] = mk(1, 0, 0, 32'h0,  1, 0,   0, 0, 32'h0,  0, 0, 0, 0);
        vecs[21] = mk(1, 0, 0, 32'h0,  0, 0,   1, 0, 32'h0,  0, 1, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n           = vecs[i].rst_n;
            hazard_stall    = vecs[i].hz;
            ex_branch_taken = vecs[i].bt;
            ex_branch_addr  = vecs[i].addr;
            imem_ready      = vecs[i].rdy;
            perf_clr        = vecs[i].clr;
            #1;
            check_vec(i);
        end

        // Saturation: clear, then 65534 freeze cycles reach 0xFFFE.
        @(negedge clk);
        hazard_stall = 1'b0; ex_branch_taken = 1'b0; ex_branch_addr = '0;
        imem_ready = 1'b1; perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        #1;
        check("sat.cleared", {16'd0, stall_cnt}, 32'h0);
        hazard_stall = 1'b1;
        for (int i = 0; i < 65534; i++) @(negedge clk);
        #1;
        check("sat.fffe", {16'd0, stall_cnt}, 32'hFFFE);
        $display("sat: after 65534 freeze cycles stall_cnt=0x%0h", stall_cnt);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("sat.ffff%0d", i), {16'd0, stall_cnt}, 32'hFFFF);
            $display("sat: freeze cycle %0d stall_cnt=0x%0h", i, stall_cnt);
        end
        // Clear beats increment while freeze is still active.
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        #1;
        check("sat.clr_beats_inc", {16'd0, stall_cnt}, 32'h0);
        $display("sat: perf_clr with freeze stall_cnt=0x%0h", stall_cnt);
        perf_clr = 1'b0;
        @(negedge clk);
        #1;
        check("sat.resume", {16'd0, stall_cnt}, 32'h1);
        $display("sat: resume stall_cnt=0x%0h", stall_cnt);
        hazard_stall = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_fetch_ctrl
